data_memory_sized: RTL and testbench

- Parametrised successor to the single-word data memory in the RV32 datapath; sits in the MEM stage between the ALU address output and the writeback mux.
- Adds byte/halfword/word stores with byte lanes selected by FUNCT3, and sign- or zero-extended sub-word loads.
- Adds a registered read path with a valid flag, and a registered error flag for out-of-range or illegal accesses.
- Depth and address width are configurable.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_load_align.sv | 36 +++
 rtl/data_memory_sized.sv | 135 +++++++++++++
 tb/tb_data_memory_sized.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: load/store funct3 encodings,
// lane geometry and the per-cycle write payload.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = WORD_W / BYTE_W;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-enabled write payload, data already replicated across lanes
  typedef struct packed {
    logic [LANES-1:0]  be;
    logic [WORD_W-1:0] data;
  } dmem_wr_t;

  // Legal funct3 encodings for a load
  function automatic logic is_load_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Legal funct3 encodings for a store
  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/halfword from a memory word and sign- or
// zero-extends it according to the load funct3. Halfwords are taken from the
// half selected by lane[1]; lane[0] is ignored for H/HU.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic [2:0]        funct3,
  output logic [WORD_W-1:0] data_c
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  // Lane selection and extension
  always_comb begin
    byte_sel = word[BYTE_W-1:0];
    half_sel = lane[1] ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
    data_c   = word;
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    case (funct3)
      F3_B:    data_c = {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      F3_BU:   data_c = {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
      F3_H:    data_c = {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      F3_HU:   data_c = {{(WORD_W-HALF_W){1'b0}}, half_sel};
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Sized RV32 data memory for the MEM stage: byte/half/word stores with lane
// enables, extended sub-word loads with a registered result and valid flag,
// and a one-cycle error pulse for rejected accesses.
// Optional build macro DMEM_MISALIGN_TRAP_EN: reject misaligned H/HU/SH and
// W/SW accesses instead of silently aligning them.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MRd,
  input  logic              MWrt,
  input  logic [2:0]        FUNCT3,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [WORD_W-1:0] W_DATA,
  output logic [WORD_W-1:0] R_DATA,
  output logic              R_VALID,
  output logic              ERR
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned AW    = IDX_W + 2;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  word_idx_c;
  logic [1:0]        lane_c;
  logic              oor_c;
  logic              ld_c;
  logic              st_c;
  logic              ld_ok_c;
  logic              st_ok_c;
  logic              err_c;
  logic [WORD_W-1:0] ld_data_c;
  dmem_wr_t          wr_c;

  assign word_idx_c = ADDR[AW-1:2];
  assign lane_c     = ADDR[1:0];

  // Out of range when any address bit above the array span is set
  generate
    if (ADDR_W > AW) begin : g_range
      assign oor_c = |ADDR[ADDR_W-1:AW];
    end else begin : g_norange
      assign oor_c = 1'b0;
    end
  endgenerate

  // A lone read or lone write is an operation; both together is rejected
  assign ld_c = MRd & ~MWrt;
  assign st_c = MWrt & ~MRd;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_c;

  // Halfwords need ADDR[0]=0, words need ADDR[1:0]=0
  always_comb begin
    misalign_c = 1'b0;
    case (FUNCT3)
      F3_H, F3_HU: misalign_c = ADDR[0];
      F3_W:        misalign_c = |ADDR[1:0];
      default:     misalign_c = 1'b0;
    endcase
  end

  assign ld_ok_c = ld_c & is_load_f3(FUNCT3)  & ~oor_c & ~misalign_c;
  assign st_ok_c = st_c & is_store_f3(FUNCT3) & ~oor_c & ~misalign_c;
`else
  assign ld_ok_c = ld_c & is_load_f3(FUNCT3)  & ~oor_c;
  assign st_ok_c = st_c & is_store_f3(FUNCT3) & ~oor_c;
`endif

  assign err_c = (MRd & MWrt) | (ld_c & ~ld_ok_c) | (st_c & ~st_ok_c);

  // Store lane enables; halfword and word lanes are forced to alignment
  always_comb begin
    wr_c = '0;
    case (FUNCT3)
      F3_B: begin
        wr_c.be   = LANES'(4'b0001 << lane_c);
        wr_c.data = {LANES{W_DATA[BYTE_W-1:0]}};
      end
      F3_H: begin
        wr_c.be   = lane_c[1] ? 4'b1100 : 4'b0011;
        wr_c.data = {2{W_DATA[HALF_W-1:0]}};
      end
      F3_W: begin
        wr_c.be   = 4'b1111;
        wr_c.data = W_DATA;
      end
      default: wr_c = '0;
    endcase
  end

  dmem_load_align u_align (
    .word   (mem[word_idx_c]),
    .lane   (lane_c),
    .funct3 (FUNCT3),
    .data_c (ld_data_c)
  );

  // Storage array: cleared on reset, byte-enabled write otherwise
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (st_ok_c) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (wr_c.be[b]) begin
          mem[word_idx_c][BYTE_W*b +: BYTE_W] <= wr_c.data[BYTE_W*b +: BYTE_W];
        end
      end
    end
  end

  // Registered load result, valid flag and error pulse
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      R_DATA  <= '0;
      R_VALID <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      R_VALID <= ld_ok_c;
      ERR     <= err_c;
      if (ld_ok_c) begin
        R_DATA <= ld_data_c;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized (DEPTH=256, ADDR_W=32).
// Expectations adapt to the DMEM_MISALIGN_TRAP_EN build macro.
module tb_data_memory_sized;
  import dmem_pkg::*;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 32;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              MRd;
  logic              MWrt;
  logic [2:0]        FUNCT3;
  logic [ADDR_W-1:0] ADDR;
  logic [31:0]       W_DATA;
  logic [31:0]       R_DATA;
  logic              R_VALID;
  logic              ERR;

  always #5 CLK = ~CLK;

  data_memory_sized #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .MRd     (MRd),
    .MWrt    (MWrt),
    .FUNCT3  (FUNCT3),
    .ADDR    (ADDR),
    .W_DATA  (W_DATA),
    .R_DATA  (R_DATA),
    .R_VALID (R_VALID),
    .ERR     (ERR)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_err;
    logic        chk_data;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_err;
    logic        chk_data;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_data, input logic exp_valid,
                              input logic exp_err, input logic chk_data);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_valid = exp_valid; v.exp_err = exp_err;
    v.chk_data = chk_data;
    return v;
  endfunction

  task automatic check_val(input int id, input string what,
                           input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %h expected %h", id, what, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge
  task automatic apply(input int id, input vec_t v);
    exp_t e;
    @(negedge CLK);
    MRd    = v.rd;
    MWrt   = v.wr;
    FUNCT3 = v.f3;
    ADDR   = v.addr;
    W_DATA = v.wdata;
    e.id = id; e.exp_data = v.exp_data; e.exp_valid = v.exp_valid;
    e.exp_err = v.exp_err; e.chk_data = v.chk_data;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL vec%0d scoreboard: got empty queue expected entry", id);
    end else begin
      e = exp_q.pop_front();
      check_val(e.id, "r_valid", 32'(R_VALID), 32'(e.exp_valid));
      check_val(e.id, "err", 32'(ERR), 32'(e.exp_err));
      if (e.chk_data) check_val(e.id, "r_data", R_DATA, e.exp_data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b0; MRd = 1'b0; MWrt = 1'b0; FUNCT3 = 3'b000; ADDR = '0; W_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_val(-1, "reset r_data", R_DATA, 32'h0);
    check_val(-1, "reset r_valid", 32'(R_VALID), 32'h0);
    check_val(-1, "reset err", 32'(ERR), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;

    // Write then confirm word 0, then reset with a load pending
    apply(-2, mk(0, 1, F3_W, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 0));
    apply(-3, mk(1, 0, F3_W, 32'h0, 32'h0, 32'hDEADBEEF, 1, 0, 1));
    @(negedge CLK);
    RESET = 1'b0; MRd = 1'b1; MWrt = 1'b0; FUNCT3 = F3_W; ADDR = 32'h0;
    @(posedge CLK);
    #1;
    check_val(-4, "reset-override r_data", R_DATA, 32'h0);
    check_val(-4, "reset-override r_valid", 32'(R_VALID), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    apply(-5, mk(1, 0, F3_W, 32'h0, 32'h0, 32'h00000000, 1, 0, 1));

    // Byte-lane stores
    vecs.push_back(mk(0, 1, F3_W,  32'h10, 32'h11223344, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, F3_B,  32'h11, 32'h000000AA, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, F3_H,  32'h12, 32'h0000BEEF, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, F3_W,  32'h10, 32'h0, 32'hBEEFAA44, 1, 0, 1));
    // Extended loads, first one back-to-back with the store
    vecs.push_back(mk(0, 1, F3_W,  32'h10, 32'h80FF7F01, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, F3_B,  32'h12, 32'h0, 32'hFFFFFFFF, 1, 0, 1));
    vecs.push_back(mk(1, 0, F3_BU, 32'h12, 32'h0, 32'h000000FF, 1, 0, 1));
    vecs.push_back(mk(1, 0, F3_B,  32'h11, 32'h0, 32'h0000007F, 1, 0, 1));
    vecs.push_back(mk(1, 0, F3_H,  32'h12, 32'h0, 32'hFFFF80FF, 1, 0, 1));
    vecs.push_back(mk(1, 0, F3_HU, 32'h12, 32'h0, 32'h000080FF, 1, 0, 1));
    // Idle cycles hold R_DATA and drop R_VALID
    vecs.push_back(mk(0, 0, F3_W,  32'h10, 32'h0, 32'h000080FF, 0, 0, 1));
    vecs.push_back(mk(0, 0, F3_W,  32'h10, 32'h0, 32'h000080FF, 0, 0, 1));
    // Errors
    vecs.push_back(mk(1, 0, F3_W,  32'h400, 32'h0, 32'h000080FF, 0, 1, 1));
    vecs.push_back(mk(0, 1, F3_W,  32'h8, 32'h55667788, 32'h000080FF, 0, 0, 1));
    vecs.push_back(mk(1, 1, F3_W,  32'h8, 32'h0, 32'h000080FF, 0, 1, 1));
    vecs.push_back(mk(1, 0, F3_W,  32'h8, 32'h0, 32'h55667788, 1, 0, 1));
    vecs.push_back(mk(0, 1, 3'b011, 32'h8, 32'h0, 32'h55667788, 0, 1, 1));
    vecs.push_back(mk(1, 0, F3_W,  32'h8, 32'h0, 32'h55667788, 1, 0, 1));
    vecs.push_back(mk(1, 0, 3'b011, 32'h8, 32'h0, 32'h55667788, 0, 1, 1));
    vecs.push_back(mk(1, 0, 3'b110, 32'h8, 32'h0, 32'h55667788, 0, 1, 1));
    // Top byte of the array, then one past the end must not alias word 0
    vecs.push_back(mk(0, 1, F3_B,  32'h3FF, 32'h000000A5, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, F3_BU, 32'h3FF, 32'h0, 32'h000000A5, 1, 0, 1));
    vecs.push_back(mk(1, 0, F3_B,  32'h3FF, 32'h0, 32'hFFFFFFA5, 1, 0, 1));
    vecs.push_back(mk(0, 1, F3_W,  32'h400, 32'hCAFEF00D, 32'h0, 0, 1, 0));
    vecs.push_back(mk(1, 0, F3_W,  32'h0, 32'h0, 32'h00000000, 1, 0, 1));
    // Misaligned word store and halfword load
    vecs.push_back(mk(0, 1, F3_W,  32'h20, 32'h0, 32'h0, 0, 0, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 1, F3_W,  32'h22, 32'h12345678, 32'h0, 0, 1, 0));
    vecs.push_back(mk(1, 0, F3_W,  32'h20, 32'h0, 32'h00000000, 1, 0, 1));
    vecs.push_back(mk(1, 0, F3_H,  32'h13, 32'h0, 32'h00000000, 0, 1, 1));
`else
    vecs.push_back(mk(0, 1, F3_W,  32'h22, 32'h12345678, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, F3_W,  32'h20, 32'h0, 32'h12345678, 1, 0, 1));
    vecs.push_back(mk(1, 0, F3_H,  32'h13, 32'h0, 32'hFFFF80FF, 1, 0, 1));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    @(negedge CLK);
    MRd = 1'b0; MWrt = 1'b0;
    if (exp_q.size() != 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
